// File: rtl/io_buttons.sv
// Memory-mapped button peripheral: synchronise, debounce and edge-detect the
// BUTTONS pins, keep sticky flags, press counters and a level interrupt.
module io_buttons #(
  parameter int unsigned NUM_BUTTONS     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SEL,
  input  logic [31:0]            ADDR,
  input  logic [31:0]            WDATA,
  input  logic [4:0]             WMASK,
  input  logic [NUM_BUTTONS-1:0] BUTTONS,
  output logic [31:0]            rdata,
  output logic                   irq
);

  localparam int unsigned NB     = NUM_BUTTONS;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PACK_W = NUM_BUTTONS * CNT_WIDTH;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_STATE    = 3'b011;
  localparam logic [2:0] OFF_PRESSED  = 3'b100;
  localparam logic [2:0] OFF_RELEASED = 3'b101;
  localparam logic [2:0] OFF_COUNT    = 3'b110;
  localparam logic [2:0] OFF_IRQ_EN   = 3'b111;

  logic [NB-1:0]        s1;
  logic [NB-1:0]        s2;
  logic [NB-1:0]        stable;
  logic [NB-1:0]        pressed;
  logic [NB-1:0]        released;
  logic [NB-1:0]        irq_en;
  logic [DB_W-1:0]      db_cnt [NB];
  logic [CNT_WIDTH-1:0] count  [NB];

  logic [NB-1:0]        accept_c;
  logic [NB-1:0]        rise_c;
  logic [NB-1:0]        fall_c;
  logic                 wr_c;
  logic [2:0]           off_c;
  logic [NB-1:0]        pressed_clr_c;
  logic [NB-1:0]        released_clr_c;
  logic                 count_clr_c;
  logic                 irq_en_wr_c;
  logic [PACK_W-1:0]    count_flat_c;
  logic [PACK_W+31:0]   count_ext_c;
  logic [31:0]          rd_word_c;
  logic                 unused_bits;

  // A level is accepted when the synchronised pin has disagreed for the full window.
  always_comb begin
    accept_c = '0;
    for (int i = 0; i < int'(NB); i++) begin
      accept_c[i] = (s2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  assign rise_c = accept_c & s2;
  assign fall_c = accept_c & ~s2;

  assign wr_c           = SEL & WMASK[0];
  assign off_c          = ADDR[4:2];
  assign pressed_clr_c  = (wr_c && off_c == OFF_PRESSED)  ? WDATA[NB-1:0] : '0;
  assign released_clr_c = (wr_c && off_c == OFF_RELEASED) ? WDATA[NB-1:0] : '0;
  assign count_clr_c    = wr_c && (off_c == OFF_COUNT);
  assign irq_en_wr_c    = wr_c && (off_c == OFF_IRQ_EN);

  always_comb begin
    count_flat_c = '0;
    for (int i = 0; i < int'(NB); i++) begin
      count_flat_c[i*CNT_WIDTH +: CNT_WIDTH] = count[i];
    end
  end

  // Zero-extend then keep the low word, so any NB*CNT_WIDTH fits 32 bits.
  assign count_ext_c = {32'b0, count_flat_c};

  always_comb begin
    rd_word_c = '0;
    case (off_c)
      OFF_STATE:    rd_word_c = 32'(stable);
      OFF_PRESSED:  rd_word_c = 32'(pressed);
      OFF_RELEASED: rd_word_c = 32'(released);
      OFF_COUNT:    rd_word_c = count_ext_c[31:0];
      OFF_IRQ_EN:   rd_word_c = 32'(irq_en);
      default:      rd_word_c = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      pressed  <= '0;
      released <= '0;
      irq_en   <= '0;
      rdata    <= '0;
      irq      <= 1'b0;
      for (int i = 0; i < int'(NB); i++) begin
        db_cnt[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      s1 <= BUTTONS;
      s2 <= s1;
      for (int i = 0; i < int'(NB); i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
        // A press on the clearing edge survives as a count of one.
        if (count_clr_c) begin
          count[i] <= CNT_WIDTH'(rise_c[i]);
        end else if (rise_c[i]) begin
          count[i] <= count[i] + CNT_WIDTH'(1);
        end
      end
      pressed  <= (pressed & ~pressed_clr_c) | rise_c;
      released <= (released & ~released_clr_c) | fall_c;
      if (irq_en_wr_c) begin
        irq_en <= WDATA[NB-1:0];
      end
      irq   <= |(pressed & irq_en);
      rdata <= SEL ? rd_word_c : '0;
    end
  end

  assign unused_bits = &{1'b0, ADDR[31:5], ADDR[1:0], WDATA[31:NB], WMASK[4:1],
                         count_ext_c[PACK_W+31:32]};

endmodule
